// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (IF fetch, MEM load/store) and the shared memory.
// slave = arbiter side, master = requesters + memory side.
interface mips_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one unified memory port with fixed read latency.
// Optional macro ARB_FAIRNESS_EN: bounds how long a waiting fetch can be starved by back-to-back data accesses.
module mips_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_mem_arbiter_if.slave    bus
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
            $error("mips_mem_arbiter: MEM_LAT must be in 1..15");
        end
        if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
            $error("mips_mem_arbiter: STARVE_MAX must fit the 4-bit starve counter (1..15)");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_start;
    logic          w_pick_dm;
    logic          w_done;
    logic          w_force_if;

    logic [3:0]    r_cnt;
    logic          r_win_dm;
    logic          r_win_we;
    logic          r_if_gnt;
    logic          r_dm_gnt;
    logic          r_if_rvalid;
    logic          r_dm_rvalid;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    // NOTE: every signal driven here gets a default before the case, so no path can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_pick_dm   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    w_start     = 1'b1;
                    w_pick_dm   = bus.dm_req && !w_force_if;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state and outputs update with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RESP is the cycle mem_rdata is valid; it is captured on leaving RESP, so rvalid and rdata appear together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_win_dm    <= 1'b0;
            r_win_we    <= 1'b0;
            r_if_gnt    <= 1'b0;
            r_dm_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_gnt    <= w_start && !w_pick_dm;
            r_dm_gnt    <= w_start && w_pick_dm;
            r_mem_en    <= w_start;
            r_mem_we    <= w_start && w_pick_dm && bus.dm_we;
            r_if_rvalid <= w_done && !r_win_dm;
            r_dm_rvalid <= w_done && r_win_dm;

            if (w_start) begin
                r_win_dm    <= w_pick_dm;
                r_win_we    <= w_pick_dm && bus.dm_we;
                r_mem_addr  <= w_pick_dm ? bus.dm_addr : bus.if_addr;
                r_mem_wdata <= w_pick_dm ? bus.dm_wdata : '0;
                r_cnt       <= 4'(MEM_LAT);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_done) begin
                if (!r_win_dm) begin
                    r_if_rdata <= bus.mem_rdata;
                end else if (!r_win_we) begin
                    r_dm_rdata <= bus.mem_rdata;
                end
            end
        end
    end

`ifdef ARB_FAIRNESS_EN
    logic [3:0] r_starve;

    assign w_force_if = bus.if_req && (r_starve >= 4'(STARVE_MAX));

    // Counts data grants taken while a fetch was waiting; any fetch grant resets the debt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_start) begin
            if (!w_pick_dm) begin
                r_starve <= '0;
            end else if (bus.if_req && r_starve != 4'hf) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end
`else
    assign w_force_if = 1'b0;
`endif

    assign bus.if_gnt    = r_if_gnt;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_gnt    = r_dm_gnt;
    assign bus.dm_rvalid = r_dm_rvalid;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3, each with its own memory model.
// Expectations for the starvation test follow ARB_FAIRNESS_EN when the bench is built with it.
module tb_mips_mem_arbiter;

    typedef struct packed {
        logic        if_gnt;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        dm_gnt;
        logic        dm_rvalid;
        logic [31:0] dm_rdata;
        logic        mem_en;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        busy;
    } outs_t;

    typedef struct {
        bit          is_dm;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n1;
    logic rst_n3;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp1[$];
    exp_t exp3[$];

    logic [31:0] m1 [256];
    bit          w1 [256];
    logic [31:0] m3 [256];
    bit          w3 [256];
    logic [31:0] p1;
    logic [31:0] p3 [3];

    mips_mem_arbiter_if #(.AW(32), .DW(32)) b1 ();
    mips_mem_arbiter_if #(.AW(32), .DW(32)) b3 ();

    mips_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .bus(b1)
    );
    mips_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n3), .bus(b3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        case (a)
            8'h00:   return 32'h2001_0005;
            8'h05:   return 32'h0000_0005;
            8'h10:   return 32'h2801_000a;
            default: return {16'hc0de, 8'h00, a};
        endcase
    endfunction

    function automatic logic [31:0] rd1(input logic [31:0] a);
        return w1[a[7:0]] ? m1[a[7:0]] : init_val(a[7:0]);
    endfunction

    function automatic logic [31:0] rd3(input logic [31:0] a);
        return w3[a[7:0]] ? m3[a[7:0]] : init_val(a[7:0]);
    endfunction

    // Memory models: data appears MEM_LAT cycles after the mem_en cycle; garbage otherwise.
    always @(posedge clk) begin
        p1 <= (b1.mem_en && !b1.mem_we) ? rd1(b1.mem_addr) : 32'hdead_beef;
        if (b1.mem_en && b1.mem_we) begin
            m1[b1.mem_addr[7:0]] <= b1.mem_wdata;
            w1[b1.mem_addr[7:0]] <= 1'b1;
        end
        p3[0] <= (b3.mem_en && !b3.mem_we) ? rd3(b3.mem_addr) : 32'hdead_beef;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        if (b3.mem_en && b3.mem_we) begin
            m3[b3.mem_addr[7:0]] <= b3.mem_wdata;
            w3[b3.mem_addr[7:0]] <= 1'b1;
        end
    end
    assign b1.mem_rdata = p1;
    assign b3.mem_rdata = p3[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic outs_t outs(input int d);
        outs_t o;
        if (d == 1)
            o = {b1.if_gnt, b1.if_rvalid, b1.if_rdata, b1.dm_gnt, b1.dm_rvalid, b1.dm_rdata,
                 b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, b1.busy};
        else
            o = {b3.if_gnt, b3.if_rvalid, b3.if_rdata, b3.dm_gnt, b3.dm_rvalid, b3.dm_rdata,
                 b3.mem_en, b3.mem_we, b3.mem_addr, b3.mem_wdata, b3.busy};
        return o;
    endfunction

    task automatic set_req(input int d, input bit is_dm, input bit req, input bit we,
                           input logic [31:0] a, input logic [31:0] wd);
        if (d == 1) begin
            if (is_dm) begin
                b1.dm_req = req; b1.dm_we = we; b1.dm_addr = a; b1.dm_wdata = wd;
            end else begin
                b1.if_req = req; b1.if_addr = a;
            end
        end else begin
            if (is_dm) begin
                b3.dm_req = req; b3.dm_we = we; b3.dm_addr = a; b3.dm_wdata = wd;
            end else begin
                b3.if_req = req; b3.if_addr = a;
            end
        end
    endtask

    // Monitor: every rvalid pops the oldest expected response for that instance.
    task automatic mon(input int d, input outs_t o);
        exp_t e;
        int   sz;
        if (!(o.if_rvalid || o.dm_rvalid)) return;
        sz = (d == 1) ? exp1.size() : exp3.size();
        if (sz == 0) begin
            check($sformatf("d%0d_unexpected_rvalid", d), {o.dm_rvalid, o.if_rvalid}, 2'b00);
            return;
        end
        if (d == 1) e = exp1.pop_front();
        else        e = exp3.pop_front();
        check($sformatf("d%0d_rvalid_port", d), {o.dm_rvalid, o.if_rvalid}, {e.is_dm, !e.is_dm});
        check($sformatf("d%0d_rdata", d), e.is_dm ? o.dm_rdata : o.if_rdata, e.data);
        check($sformatf("d%0d_rvalid_cycle", d), cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        mon(1, outs(1));
        mon(3, outs(3));
    end

    // Called at a negedge: raise req, wait for its grant, verify the memory strobe, drop req.
    task automatic access(input int d, input bit is_dm, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input int gnt_at);
        outs_t o;
        bit    got = 1'b0;
        set_req(d, is_dm, 1'b1, we, a, wd);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            o = outs(d);
            if (is_dm ? o.dm_gnt : o.if_gnt) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("d%0d_%s_gnt_seen", d, is_dm ? "dm" : "if"), got, 1'b1);
        if (got) begin
            check($sformatf("d%0d_%s_gnt_cycle", d, is_dm ? "dm" : "if"), cyc, gnt_at);
            check($sformatf("d%0d_mem_strobe", d), {o.mem_en, o.mem_we, o.mem_addr}, {1'b1, we, a});
            if (we) check($sformatf("d%0d_mem_wdata", d), o.mem_wdata, wd);
        end
        set_req(d, is_dm, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp1.size() == 0 && exp3.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("scoreboard_drained", ok, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   s;
        int   n_if_gnt;
        bit   exp_if;
        bit   reached;
        outs_t o;

        rst_n1 = 1'b0;
        rst_n3 = 1'b0;
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, '0, '0);
        set_req(3, 1'b0, 1'b0, 1'b0, '0, '0);
        set_req(3, 1'b1, 1'b0, 1'b0, '0, '0);

        // Reset with random request activity: everything stays quiet.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b1.if_req = 1'($urandom_range(0, 1));
            b1.dm_req = 1'($urandom_range(0, 1));
            b1.dm_we  = 1'($urandom_range(0, 1));
            b3.if_req = 1'($urandom_range(0, 1));
            b3.dm_req = 1'($urandom_range(0, 1));
            #1;
            check("d1_outputs_in_reset", outs(1) != '0, 1'b0);
            check("d3_outputs_in_reset", outs(3) != '0, 1'b0);
        end
        @(negedge clk);
        b1.if_req = 1'b0; b1.dm_req = 1'b0; b1.dm_we = 1'b0;
        b3.if_req = 1'b0; b3.dm_req = 1'b0;
        rst_n1 = 1'b1;
        rst_n3 = 1'b1;
        @(negedge clk);
        check("d1_outputs_after_release", outs(1) != '0, 1'b0);
        check("d3_outputs_after_release", outs(3) != '0, 1'b0);

        // Single fetch, MEM_LAT=1.
        s = cyc + 1;
        exp1.push_back('{1'b0, 32'h2801_000a, s + 2});
        access(1, 1'b0, 1'b0, 32'h10, '0, s);
        drain();

        // Fetch and store together: store first, fetch right after its rvalid.
        s = cyc + 1;
        exp1.push_back('{1'b1, 32'h0000_0000, s + 2});
        exp1.push_back('{1'b0, 32'h2001_0005, s + 5});
        fork
            access(1, 1'b1, 1'b1, 32'h20, 32'hfc00_0000, s);
            access(1, 1'b0, 1'b0, 32'h00, '0, s + 3);
        join
        drain();
        check("d1_store_landed", rd1(32'h20), 32'hfc00_0000);

        // Both requesters held: 20 back-to-back grants.
        s = cyc + 1;
        n_if_gnt = 0;
        set_req(1, 1'b0, 1'b1, 1'b0, 32'h10, '0);
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h05, '0);
        for (int i = 0; i < 20; i++) begin
`ifdef ARB_FAIRNESS_EN
            exp_if = (i % 5 == 4);
`else
            exp_if = 1'b0;
`endif
            exp1.push_back('{!exp_if, exp_if ? 32'h2801_000a : 32'h0000_0005, s + 3 * i + 2});
        end
        for (int i = 0; i < 20; i++) begin
`ifdef ARB_FAIRNESS_EN
            exp_if = (i % 5 == 4);
`else
            exp_if = 1'b0;
`endif
            reached = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (cyc == s + 3 * i) begin
                    reached = 1'b1;
                    break;
                end
            end
            o = outs(1);
            if (o.if_gnt) n_if_gnt++;
            check($sformatf("d1_hold_grant_%0d", i), {reached, o.dm_gnt, o.if_gnt}, {1'b1, !exp_if, exp_if});
        end
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b1, 1'b0, 1'b0, '0, '0);
`ifdef ARB_FAIRNESS_EN
        check("d1_if_grants_in_20", n_if_gnt, 4);
`else
        check("d1_if_grants_in_20", n_if_gnt, 0);
`endif
        drain();

        // Load, MEM_LAT=3.
        s = cyc + 1;
        exp3.push_back('{1'b1, 32'h0000_0005, s + 4});
        access(3, 1'b1, 1'b0, 32'h05, '0, s);
        drain();

        // Reset pulsed while the fetch is in WAIT: the access vanishes.
        s = cyc + 1;
        access(3, 1'b0, 1'b0, 32'h10, '0, s);
        @(negedge clk);
        rst_n3 = 1'b0;
        #1;
        check("d3_outputs_reset_in_wait", outs(3) != '0, 1'b0);
        @(negedge clk);
        rst_n3 = 1'b1;
        repeat (8) @(negedge clk);
        check("d3_idle_after_abort", outs(3).busy, 1'b0);
        s = cyc + 1;
        exp3.push_back('{1'b0, 32'h2801_000a, s + 4});
        access(3, 1'b0, 1'b0, 32'h10, '0, s);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
